pipe_result_collect: RTL and testbench
======================================

// Module: pipe_result_collect
// PURPOSE
//   Downstream collector for the 3-stage arithmetic pipeline result F.
//   The pipeline has no backpressure, so this block buffers each valid F in a
//   DEPTH-entry show-ahead FIFO and presents it to a valid/ready consumer.
//   It also keeps a running sum and an accepted-word count for checking.
//   Words that arrive while the FIFO cannot accept them are dropped and flagged.
// PARAMETERS
//   N      10  data width of F (matches pipeline N)
//   DEPTH  4   FIFO entries; must be a power of two, >= 2
//   ACC_W  16  width of acc_sum; wraps modulo 2^ACC_W
// PORTS
//   clk        in   1              single clock; all state updates on posedge
//   rst_n      in   1              asynchronous, active-low reset
//   clr        in   1              synchronous clear (see BEHAVIOUR)
//   in_valid   in   1              in_data is a valid pipeline result this cycle
//   in_data    in   N              pipeline output F
//   out_ready  in   1              consumer accepts out_data this cycle
//   out_valid  out  1              FIFO head is valid
//   out_data   out  N              FIFO head word (show-ahead)
//   count      out  clog2(DEPTH)+1 number of occupied entries
//   full       out  1              count == DEPTH
//   empty      out  1              count == 0
//   overflow   out  1              sticky: at least one word dropped
//   drop_cnt   out  8              dropped words, saturates at 255
//   acc_sum    out  ACC_W          sum of all accepted in_data, modulo 2^ACC_W
//   acc_cnt    out  16             accepted words, wraps at 2^16
// BEHAVIOUR
//   Reset: the clock is clk. rst_n is asynchronous and active-low. Asserting
//     rst_n immediately clears the pointers, count, acc_sum, acc_cnt, overflow
//     and drop_cnt, with no clock edge needed. Outputs then read out_valid=0,
//     empty=1, full=0, count=0 and out_data=0.
//   Reset mid-operation discards all buffered words. Normal operation resumes
//     on the first posedge after rst_n deasserts.
//   pop  = out_valid & out_ready.
//   push = in_valid & (~full | pop).
//   drop = in_valid & full & ~pop.
//   On a push: in_data is written at wr_ptr, wr_ptr advances, and acc_sum
//     advances by in_data zero-extended to ACC_W (truncated on wrap).
//     acc_cnt increments.
//   On a pop: rd_ptr advances.
//   Both pointers wrap modulo DEPTH. count changes by +1 on push only, -1 on
//     pop only, and 0 on both or neither.
//   Simultaneous push and pop when full is legal: the head leaves, the new word
//     enters, count stays DEPTH, and no drop occurs.
//   Simultaneous push and pop when count==1: out_data shows the new word the
//     next cycle.
//   Pop when empty cannot occur, because out_valid=0 when empty.
//   On a drop: the word is discarded and is not added to acc_sum or acc_cnt.
//     overflow is set to 1 and drop_cnt is incremented (held at 255).
//   Latency: a word pushed at edge k into an empty FIFO gives out_valid=1 and
//     out_data=word after edge k, i.e. one cycle. No combinational in->out path.
//   out_data = mem[rd_ptr]. It holds a stable value while out_valid & ~out_ready.
//   out_data is not defined to change when empty beyond the reset value.
//   clr=1 at a posedge has the same effect as reset and overrides push, pop and
//     drop in that cycle. The input word in that cycle is not stored.
//   full and empty are decoded from count and are registered-consistent: no glitch
//     on the same edge as a push or pop.
// TESTING
//   1. Drive rst_n=0 mid-clock-phase -> out_valid=0, empty=1, count=0,
//      acc_sum=0 and overflow=0 before the next edge.
//   2. With out_ready=0, push 99,150,8 -> count=3, out_data=99, acc_sum=257,
//      acc_cnt=3.
//   3. Push 62 (full=1), then push 0 with out_ready=0 -> count=4, overflow=1,
//      drop_cnt=1, acc_sum=319, acc_cnt=4.
//   4. Full, out_ready=1, push 66 in the same cycle -> 99 consumed, count=4,
//      drop_cnt=1, acc_sum=385.
//   5. Drain with out_ready=1 and no input -> out_data 150,8,62,66 on
//      consecutive cycles, then empty=1 and out_valid=0.
//   6. ACC_W=8: push 200 then 100 -> acc_sum=44 (wrap).
//      Then clr=1 together with in_valid (word 5) -> all cleared, word 5 not
//      stored.

Source files
------------

// File: rtl/pipe_result_collect.sv
// Show-ahead FIFO collector for pipeline results F, with running sum/count of accepted
// words and drop accounting for words arriving while the FIFO cannot take them.
module pipe_result_collect #(
  parameter int unsigned N     = 10,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned ACC_W = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clr,
  input  logic                       in_valid,
  input  logic [N-1:0]               in_data,
  input  logic                       out_ready,
  output logic                       out_valid,
  output logic [N-1:0]               out_data,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty,
  output logic                       overflow,
  output logic [7:0]                 drop_cnt,
  output logic [ACC_W-1:0]           acc_sum,
  output logic [15:0]                acc_cnt
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [N-1:0]     mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic [ACC_W-1:0] acc_sum_q;
  logic [15:0]      acc_cnt_q;
  logic             overflow_q;
  logic [7:0]       drop_cnt_q;

  logic             push, pop, drop;
  logic [ACC_W-1:0] in_ext;

  assign full      = (count_q == CW'(DEPTH));
  assign empty     = (count_q == '0);
  assign out_valid = ~empty;
  assign pop       = out_valid & out_ready;
  assign push      = in_valid & (~full | pop);
  assign drop      = in_valid & full & ~pop;
  assign in_ext    = ACC_W'(in_data);

  // Head is forced to zero when empty so reset/clear read back 0 without clearing storage.
  assign out_data  = empty ? '0 : mem_q[rd_ptr_q];
  assign count     = count_q;
  assign overflow  = overflow_q;
  assign drop_cnt  = drop_cnt_q;
  assign acc_sum   = acc_sum_q;
  assign acc_cnt   = acc_cnt_q;

  always_ff @(posedge clk) begin
    if (push && !clr) begin
      mem_q[wr_ptr_q] <= in_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      acc_sum_q  <= '0;
      acc_cnt_q  <= '0;
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
    end else if (clr) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      acc_sum_q  <= '0;
      acc_cnt_q  <= '0;
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      if (push) begin
        wr_ptr_q  <= wr_ptr_q + PW'(1);
        acc_sum_q <= acc_sum_q + in_ext;
        acc_cnt_q <= acc_cnt_q + 16'd1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PW'(1);
      end
      if (push && !pop) begin
        count_q <= count_q + CW'(1);
      end else if (pop && !push) begin
        count_q <= count_q - CW'(1);
      end
      if (drop) begin
        overflow_q <= 1'b1;
        if (drop_cnt_q != 8'hFF) begin
          drop_cnt_q <= drop_cnt_q + 8'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_pipe_result_collect.sv
// Randomized scoreboard bench for pipe_result_collect: a queue-based reference model
// predicts FIFO contents, occupancy, sums and drops; a monitor checks pops and status.
module tb_pipe_result_collect;

  localparam int N     = 10;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          clr = 1'b0;
  logic          in_valid = 1'b0;
  logic [N-1:0]  in_data = '0;
  logic          out_ready = 1'b0;

  logic          out_valid, full, empty, overflow;
  logic [N-1:0]  out_data;
  logic [2:0]    count;
  logic [7:0]    drop_cnt;
  logic [15:0]   acc_sum, acc_cnt;

  logic          out_valid8, full8, empty8, overflow8;
  logic [N-1:0]  out_data8;
  logic [2:0]    count8;
  logic [7:0]    drop_cnt8;
  logic [7:0]    acc_sum8;
  logic [15:0]   acc_cnt8;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pipe_result_collect #(.N(N), .DEPTH(DEPTH), .ACC_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_data(in_data),
    .out_ready(out_ready), .out_valid(out_valid), .out_data(out_data), .count(count),
    .full(full), .empty(empty), .overflow(overflow), .drop_cnt(drop_cnt),
    .acc_sum(acc_sum), .acc_cnt(acc_cnt)
  );

  pipe_result_collect #(.N(N), .DEPTH(DEPTH), .ACC_W(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_data(in_data),
    .out_ready(out_ready), .out_valid(out_valid8), .out_data(out_data8), .count(count8),
    .full(full8), .empty(empty8), .overflow(overflow8), .drop_cnt(drop_cnt8),
    .acc_sum(acc_sum8), .acc_cnt(acc_cnt8)
  );

  // Reference model: contents as a queue, sums as unbounded integers reduced on compare.
  int unsigned exp_q[$];
  int          m_cnt  = 0;
  longint      m_sum  = 0;
  int          m_acc  = 0;
  bit          m_ovf  = 1'b0;
  int          m_drop = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n || clr) begin
      exp_q.delete();
      m_cnt  = 0;
      m_sum  = 0;
      m_acc  = 0;
      m_ovf  = 1'b0;
      m_drop = 0;
    end else begin
      bit p_pop, p_push;
      p_pop  = (m_cnt > 0) && out_ready;
      p_push = in_valid && ((m_cnt < DEPTH) || p_pop);
      if (p_push) begin
        exp_q.push_back(int'(in_data));
        m_sum += in_data;
        m_acc++;
      end else if (in_valid) begin
        m_ovf = 1'b1;
        if (m_drop < 255) m_drop++;
      end
      m_cnt += (p_push ? 1 : 0) - (p_pop ? 1 : 0);
    end
  end

  // Monitor: runs mid-cycle, checks status and consumes the scoreboard on each pop.
  always @(negedge clk) begin
    chk("count", count, m_cnt);
    chk("out_valid", out_valid, m_cnt > 0);
    chk("full", full, m_cnt == DEPTH);
    chk("empty", empty, m_cnt == 0);
    chk("overflow", overflow, m_ovf);
    chk("drop_cnt", drop_cnt, m_drop);
    chk("acc_sum", acc_sum, m_sum % 65536);
    chk("acc_cnt", acc_cnt, m_acc % 65536);
    chk("acc_sum8", acc_sum8, m_sum % 256);
    chk("count8", count8, m_cnt);
    if (out_valid && out_ready && !clr && rst_n) begin
      if (exp_q.size() == 0) begin
        chk("pop_on_empty_model", 1, 0);
      end else begin
        chk("out_data", out_data, exp_q.pop_front());
      end
    end
  end

  // Inputs change 1 time unit after posedge and are consumed at the following posedge.
  task automatic step(input bit v, input int d, input bit r, input bit c);
    in_valid  = v;
    in_data   = N'(d);
    out_ready = r;
    clr       = c;
    @(posedge clk);
    #1;
  endtask

  initial begin
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Fill without draining
    step(1, 99, 0, 0);
    step(1, 150, 0, 0);
    step(1, 8, 0, 0);
    chk("t2_count", count, 3);
    chk("t2_out_data", out_data, 99);
    chk("t2_acc_sum", acc_sum, 257);
    chk("t2_acc_cnt", acc_cnt, 3);

    // Reach full, then drop
    step(1, 62, 0, 0);
    chk("t3_full", full, 1);
    step(1, 0, 0, 0);
    chk("t3_count", count, 4);
    chk("t3_overflow", overflow, 1);
    chk("t3_drop_cnt", drop_cnt, 1);
    chk("t3_acc_sum", acc_sum, 319);
    chk("t3_acc_cnt", acc_cnt, 4);

    // Push and pop together while full
    step(1, 66, 1, 0);
    chk("t4_count", count, 4);
    chk("t4_drop_cnt", drop_cnt, 1);
    chk("t4_acc_sum", acc_sum, 385);
    chk("t4_head", out_data, 150);

    // Drain
    step(0, 0, 1, 0);
    chk("t5_head1", out_data, 8);
    step(0, 0, 1, 0);
    chk("t5_head2", out_data, 62);
    step(0, 0, 1, 0);
    chk("t5_head3", out_data, 66);
    step(0, 0, 1, 0);
    chk("t5_empty", empty, 1);
    chk("t5_out_valid", out_valid, 0);

    // Narrow accumulator wrap, then clear with a word present
    step(0, 0, 0, 1);
    step(1, 200, 0, 0);
    step(1, 100, 0, 0);
    chk("t6_acc_sum8", acc_sum8, 44);
    chk("t6_acc_sum16", acc_sum, 300);
    step(1, 5, 0, 1);
    chk("t6_clr_count", count, 0);
    chk("t6_clr_acc_cnt", acc_cnt, 0);
    chk("t6_clr_acc_sum", acc_sum, 0);
    chk("t6_clr_valid", out_valid, 0);
    chk("t6_clr_out_data", out_data, 0);

    // Count==1 with simultaneous push and pop: new word becomes head
    step(1, 17, 0, 0);
    step(1, 300, 1, 0);
    chk("c1_head", out_data, 300);
    chk("c1_count", count, 1);

    // Randomized traffic with occasional clears
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 3) != 0, $urandom_range(0, 1023),
           $urandom_range(0, 2) == 0, $urandom_range(0, 79) == 0);
    end

    // Asynchronous reset mid-phase with words buffered
    step(1, 511, 0, 0);
    step(1, 7, 0, 0);
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("t1_out_valid", out_valid, 0);
    chk("t1_empty", empty, 1);
    chk("t1_full", full, 0);
    chk("t1_count", count, 0);
    chk("t1_acc_sum", acc_sum, 0);
    chk("t1_overflow", overflow, 0);
    chk("t1_drop_cnt", drop_cnt, 0);
    chk("t1_out_data", out_data, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(1, 42, 0, 0);
    chk("t1_resume", out_data, 42);
    step(0, 0, 1, 0);
    step(0, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
